// File: rtl/rx_tlp_sender.sv
// rx_tlp_sender: turns rx_tlp_trigger requests into 64-bit memory-write TLPs into host huge pages
// Ports:
//   clk, reset_n                         core clock, async active-low reset
//   trigger_tlp / trigger_tlp_ack        16-qword data TLP request / completion pulse
//   send_last_tlp, qwords_to_send        final data TLP (0..16 qwords) followed by page close
//   change_huge_page / _ack              page close request / completion pulse (also acks send_last_tlp)
//   rd_addr, rd_data                     RX buffer read port, one-cycle read latency
//   hp_addr_*, hp_ready_*, hp_done_*     host huge-page bases, availability, hand-back pulses
//   cfg_completer_id                     requester ID for the TLP header
//   tx_tdata/tkeep/tvalid/tlast/tready   PCIe core TX AXI-stream
module rx_tlp_sender #(
    parameter int BUF_AW = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trigger_tlp,
    output logic              trigger_tlp_ack,
    input  logic              send_last_tlp,
    input  logic              change_huge_page,
    output logic              change_huge_page_ack,
    input  logic [4:0]        qwords_to_send,
    output logic [BUF_AW-1:0] rd_addr,
    input  logic [63:0]       rd_data,
    input  logic [63:0]       hp_addr_0,
    input  logic [63:0]       hp_addr_1,
    input  logic              hp_ready_0,
    input  logic              hp_ready_1,
    output logic              hp_done_0,
    output logic              hp_done_1,
    input  logic [15:0]       cfg_completer_id,
    output logic [63:0]       tx_tdata,
    output logic [7:0]        tx_tkeep,
    output logic              tx_tvalid,
    output logic              tx_tlast,
    input  logic              tx_tready
);
    typedef enum logic [3:0] {
        IDLE, WAIT_PAGE, HDR0, HDR1, DATA, ACK, CL_HDR0, CL_HDR1, CL_DATA, SWITCH
    } state_t;

    state_t            state, state_nx;
    logic              page_sel, closing, no_data, inflight, pop, issue, page_ready;
    logic [18:0]       page_offset;
    logic [BUF_AW-1:0] rd_ptr;
    logic [4:0]        nq, fetch_rem, beats_left;
    logic [63:0]       q0, q1, base, addr;
    logic [1:0]        cnt;
    logic [2:0]        occ;
    logic [9:0]        len;
    logic [31:0]       dw0, dw1;

    // rd_ptr advances as reads are issued; every issued read is sent before the TLP ends,
    // so between TLPs it equals the count of transmitted qwords.
    assign rd_addr    = rd_ptr;
    assign tx_tkeep   = {8{tx_tvalid}};
    assign page_ready = page_sel ? hp_ready_1 : hp_ready_0;
    assign base       = page_sel ? hp_addr_1 : hp_addr_0;
    assign addr       = base + {42'b0, page_offset, 3'b0};
    assign len        = (state == CL_HDR0) ? 10'd2 : {4'b0, nq, 1'b0};
    assign dw0        = {1'b0, 2'b11, 5'b0, 1'b0, 3'b0, 4'b0, 1'b0, 1'b0, 2'b0, 2'b0, len};
    assign dw1        = {cfg_completer_id, 8'h00, 4'hF, 4'hF};
    assign pop        = (state == DATA) && (cnt != 2'd0) && tx_tready;
    // Prefetch keeps (buffered + in-flight) qwords at most 2 after this cycle's pop.
    assign occ        = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue      = (fetch_rem != 5'd0) && (occ < 3'd2);

    always_comb begin
        state_nx             = state;
        tx_tvalid            = 1'b0;
        tx_tlast             = 1'b0;
        tx_tdata             = 64'h0;
        trigger_tlp_ack      = 1'b0;
        change_huge_page_ack = 1'b0;
        hp_done_0            = 1'b0;
        hp_done_1            = 1'b0;
        case (state)
            IDLE:      if (send_last_tlp || change_huge_page || trigger_tlp) state_nx = WAIT_PAGE;
            WAIT_PAGE: if (page_ready) state_nx = no_data ? CL_HDR0 : HDR0;
            HDR0, CL_HDR0: begin
                tx_tvalid = 1'b1;
                tx_tdata  = {dw1, dw0};
                if (tx_tready) state_nx = (state == HDR0) ? HDR1 : CL_HDR1;
            end
            HDR1: begin
                tx_tvalid = 1'b1;
                tx_tdata  = {addr[31:0], addr[63:32]};
                if (tx_tready) state_nx = DATA;
            end
            DATA: begin
                tx_tvalid = cnt != 2'd0;
                tx_tdata  = q0;
                tx_tlast  = beats_left == 5'd1;
                if (pop && beats_left == 5'd1) state_nx = closing ? CL_HDR0 : ACK;
            end
            CL_HDR1: begin
                tx_tvalid = 1'b1;
                tx_tdata  = {base[31:0], base[63:32]};
                if (tx_tready) state_nx = CL_DATA;
            end
            CL_DATA: begin
                tx_tvalid = 1'b1;
                tx_tlast  = 1'b1;
                tx_tdata  = {45'b0, page_offset};
                if (tx_tready) state_nx = SWITCH;
            end
            SWITCH: begin
                hp_done_0 = ~page_sel;
                hp_done_1 = page_sel;
                state_nx  = ACK;
            end
            ACK: begin
                trigger_tlp_ack      = ~closing;
                change_huge_page_ack = closing;
                state_nx             = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            page_sel    <= 1'b0;
            page_offset <= 19'h10;
            rd_ptr      <= '0;
            nq          <= 5'd0;
            fetch_rem   <= 5'd0;
            beats_left  <= 5'd0;
            closing     <= 1'b0;
            no_data     <= 1'b0;
            inflight    <= 1'b0;
            cnt         <= 2'd0;
            q0          <= 64'h0;
            q1          <= 64'h0;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            if (issue) begin
                rd_ptr    <= rd_ptr + BUF_AW'(1);
                fetch_rem <= fetch_rem - 5'd1;
            end
            if (state == IDLE) begin
                if (send_last_tlp) begin
                    closing    <= 1'b1;
                    no_data    <= qwords_to_send == 5'd0;
                    nq         <= qwords_to_send;
                    fetch_rem  <= qwords_to_send;
                    beats_left <= qwords_to_send;
                end else if (change_huge_page) begin
                    closing    <= 1'b1;
                    no_data    <= 1'b1;
                    nq         <= 5'd0;
                    fetch_rem  <= 5'd0;
                    beats_left <= 5'd0;
                end else if (trigger_tlp) begin
                    closing    <= 1'b0;
                    no_data    <= 1'b0;
                    nq         <= 5'd16;
                    fetch_rem  <= 5'd16;
                    beats_left <= 5'd16;
                end
            end
            if (pop) begin
                beats_left  <= beats_left - 5'd1;
                page_offset <= page_offset + 19'd1;
            end
            if (state == SWITCH) begin
                page_sel    <= ~page_sel;
                page_offset <= 19'h10;
            end
            // Two-entry prefetch FIFO, q0 is the head; inflight marks rd_data carrying a fetched qword.
            if (inflight && pop) begin
                if (cnt == 2'd1) q0 <= rd_data;
                else begin
                    q0 <= q1;
                    q1 <= rd_data;
                end
            end else if (inflight) begin
                if (cnt == 2'd0) q0 <= rd_data;
                else q1 <= rd_data;
                cnt <= cnt + 2'd1;
            end else if (pop) begin
                q0  <= q1;
                cnt <= cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_rx_tlp_sender.sv
// tb_rx_tlp_sender: scoreboard bench for rx_tlp_sender with a 16-entry RX buffer model
module tb_rx_tlp_sender;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          trigger_tlp, send_last_tlp, change_huge_page;
    logic          trigger_tlp_ack, change_huge_page_ack;
    logic [4:0]    qwords_to_send;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [63:0]   hp_addr_0, hp_addr_1;
    logic          hp_ready_0, hp_ready_1, hp_done_0, hp_done_1;
    logic [15:0]   cfg_completer_id;
    logic [63:0]   tx_tdata;
    logic [7:0]    tx_tkeep;
    logic          tx_tvalid, tx_tlast, tx_tready;

    rx_tlp_sender #(.BUF_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .trigger_tlp(trigger_tlp), .trigger_tlp_ack(trigger_tlp_ack),
        .send_last_tlp(send_last_tlp), .change_huge_page(change_huge_page),
        .change_huge_page_ack(change_huge_page_ack), .qwords_to_send(qwords_to_send),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .hp_addr_0(hp_addr_0), .hp_addr_1(hp_addr_1),
        .hp_ready_0(hp_ready_0), .hp_ready_1(hp_ready_1),
        .hp_done_0(hp_done_0), .hp_done_1(hp_done_1),
        .cfg_completer_id(cfg_completer_id),
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid),
        .tx_tlast(tx_tlast), .tx_tready(tx_tready)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [16];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int n_checks = 0, n_fail = 0;
    int n_tack = 0, n_cack = 0, n_done0 = 0, n_done1 = 0;
    int e_tack = 0, e_cack = 0, e_done0 = 0, e_done1 = 0;
    logic [64:0] sb [$];
    logic        rand_rdy = 1'b0;
    logic        m_sel;
    logic [18:0] m_off;
    logic [3:0]  m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #2 tx_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic        prev_stall = 1'b0, prev_last;
    logic [63:0] prev_data;
    always @(negedge clk) begin
        logic [64:0] e;
        if (!reset_n) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                check("stall_valid", 64'(tx_tvalid), 1);
                check("stall_data", tx_tdata, prev_data);
                check("stall_last", 64'(tx_tlast), 64'(prev_last));
            end
            if (tx_tvalid && tx_tready) begin
                check("tkeep", 64'(tx_tkeep), 64'hFF);
                if (sb.size() == 0) check("extra_beat", 64'(tx_tvalid), 0);
                else begin
                    e = sb.pop_front();
                    check("beat_data", tx_tdata, e[63:0]);
                    check("beat_last", 64'(tx_tlast), 64'(e[64]));
                end
            end
            prev_stall = tx_tvalid && !tx_tready;
            prev_data  = tx_tdata;
            prev_last  = tx_tlast;
            n_tack  += int'(trigger_tlp_ack);
            n_cack  += int'(change_huge_page_ack);
            n_done0 += int'(hp_done_0);
            n_done1 += int'(hp_done_1);
        end
    end

    task automatic exp_hdr(input logic [9:0] len, input logic [63:0] a);
        sb.push_back({1'b0, cfg_completer_id, 8'h00, 8'hFF, 32'h6000_0000 | {22'b0, len}});
        sb.push_back({1'b0, a[31:0], a[63:32]});
    endtask

    task automatic exp_data(input int n);
        logic [63:0] base;
        base = m_sel ? hp_addr_1 : hp_addr_0;
        exp_hdr(10'(2 * n), base + {42'b0, m_off, 3'b0});
        for (int i = 0; i < n; i++) begin
            sb.push_back({i == n - 1, mem[m_ptr]});
            m_ptr++;
            m_off++;
        end
    endtask

    task automatic exp_close();
        exp_hdr(10'd2, m_sel ? hp_addr_1 : hp_addr_0);
        sb.push_back({1'b1, 45'b0, m_off});
        if (m_sel) e_done1++;
        else e_done0++;
        m_sel = ~m_sel;
        m_off = 19'h10;
    endtask

    task automatic check_counts();
        check("tack_count", 64'(n_tack), 64'(e_tack));
        check("cack_count", 64'(n_cack), 64'(e_cack));
        check("done0_count", 64'(n_done0), 64'(e_done0));
        check("done1_count", 64'(n_done1), 64'(e_done1));
    endtask

    // kind: 0 trigger_tlp, 1 send_last_tlp, 2 change_huge_page
    task automatic run_req(input int kind, input int qws, input int stall);
        logic sel0, got;
        int   n, seen;
        sel0 = m_sel;
        n = (kind == 0) ? 16 : (kind == 1) ? qws : 0;
        if (n > 0) exp_data(n);
        if (kind != 0) exp_close();
        if (kind == 0) e_tack++;
        else e_cack++;
        if (stall > 0) begin
            if (sel0) hp_ready_1 = 1'b0;
            else hp_ready_0 = 1'b0;
        end
        qwords_to_send   = 5'(qws);
        trigger_tlp      = kind == 0;
        send_last_tlp    = kind == 1;
        change_huge_page = kind == 2;
        if (stall > 0) begin
            seen = 0;
            repeat (stall) begin
                @(negedge clk);
                seen += int'(tx_tvalid);
            end
            check("page_stall", 64'(seen), 0);
            hp_ready_0 = 1'b1;
            hp_ready_1 = 1'b1;
        end else begin
            repeat (2) @(negedge clk);
            check("hdr_latency", 64'(tx_tvalid), 1);
        end
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (trigger_tlp_ack || change_huge_page_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", 64'(got), 1);
        check("ack_kind", 64'({trigger_tlp_ack, change_huge_page_ack}), (kind == 0) ? 64'd2 : 64'd1);
        trigger_tlp      = 1'b0;
        send_last_tlp    = 1'b0;
        change_huge_page = 1'b0;
        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 0);
        check_counts();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {32'hD000_0000 + 32'(i), $urandom};
        reset_n          = 1'b0;
        tx_tready        = 1'b1;
        trigger_tlp      = 1'b0;
        send_last_tlp    = 1'b0;
        change_huge_page = 1'b0;
        qwords_to_send   = 5'd0;
        hp_addr_0        = 64'h1_0000_0000;
        hp_addr_1        = 64'h2_3450_0000;
        hp_ready_0       = 1'b1;
        hp_ready_1       = 1'b1;
        cfg_completer_id = 16'hBEEF;
        m_sel = 1'b0;
        m_off = 19'h10;
        m_ptr = 4'd0;
        repeat (4) @(negedge clk);
        check("rst_tvalid", 64'(tx_tvalid), 0);
        check("rst_tkeep", 64'(tx_tkeep), 0);
        check("rst_tdata", tx_tdata, 0);
        check("rst_tlast", 64'(tx_tlast), 0);
        check("rst_rd_addr", 64'(rd_addr), 0);
        check("rst_outs", 64'({trigger_tlp_ack, change_huge_page_ack, hp_done_0, hp_done_1}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_req(0, 0, 0);
        rand_rdy = 1'b1;
        run_req(0, 0, 0);
        run_req(0, 0, 0);
        run_req(2, 0, 0);
        run_req(1, 5, 0);
        rand_rdy = 1'b0;
        run_req(0, 0, 0);
        run_req(1, 0, 0);
        run_req(0, 0, 20);
        rand_rdy = 1'b1;
        run_req(1, 8, 0);
        run_req(0, 0, 0);
        rand_rdy = 1'b0;

        // reset in the middle of a data TLP
        exp_data(16);
        trigger_tlp = 1'b1;
        for (int i = 0; i < 200 && sb.size() > 8; i++) @(negedge clk);
        check("pre_reset_valid", 64'(tx_tvalid), 1);
        reset_n = 1'b0;
        #1;
        check("reset_drops_valid", 64'(tx_tvalid), 0);
        check("reset_rd_addr", 64'(rd_addr), 0);
        trigger_tlp = 1'b0;
        sb.delete();
        m_sel = 1'b0;
        m_off = 19'h10;
        m_ptr = 4'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_counts();
        run_req(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
